sample_stretcher: RTL and testbench
===================================

Name: sample_stretcher

Overview:
Inverse of the capture-side clock-divider sampler. Takes a stream of samples and replays each one (d+1) times on its output stream, where d is the programmed divider, so output rate = input rate × (d+1). Sits on the pattern-generator / replay path. It turns decimated sample memory back into a full-rate stream for test outputs and loopback checks against the capture path.

Parameters:
DW, 32, sample data width
CW, 24, repeat-counter and divider width (CW <= 32)

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wrDivider  input  1  one-cycle strobe: load divider from cmd_data[CW-1:0]
cmd_data  input  32  configuration data
sti_tready  output  1  input stream ready
sti_tvalid  input  1  input stream valid
sti_tdata  input  DW  input sample
sto_tready  input  1  output stream ready
sto_tvalid  output  1  output stream valid
sto_tdata  output  DW  output sample (registered)
sto_tlast  output  1  high on final repetition of current sample
busy  output  1  holding register occupied (equals sto_tvalid)

Behaviour:
- Reset is asynchronous on rst_n low and applies to all state. divider=0, repeat counter=0, full=0, data_q=0. Outputs after reset: sto_tvalid=0, sto_tlast=0, busy=0, sto_tdata=0, sti_tready=1.
- Divider register: on wrDivider, divider <= cmd_data[CW-1:0]. Upper bits are ignored. The new value applies only to samples accepted after the write edge. The count of a sample already held is never altered.
- State: a single holding register (data_q, full) plus a repeat counter cnt[CW-1:0] that counts remaining extra repetitions.
- Transfer definitions: in_xfer = sti_tvalid & sti_tready; out_xfer = sto_tvalid & sto_tready.
- Combinational outputs:
  - last = (cnt == 0)
  - sti_tready = ~full | (sto_tready & last). This is combinational from sto_tready, with no combinational path from sti_tvalid.
  - sto_tvalid = busy = full
  - sto_tdata = data_q
  - sto_tlast = full & last
- Sequential, priority as listed:
  - in_xfer: data_q <= sti_tdata, cnt <= divider (value at that edge, before any same-edge wrDivider update), full <= 1.
  - else out_xfer & last: full <= 0. data_q holds its value.
  - else out_xfer: cnt <= cnt - 1.
  - otherwise: hold.
- Latency: a sample accepted at edge N is presented on sto_tdata/sto_tvalid after edge N and emitted exactly divider+1 times, through the final repetition carrying sto_tlast.
- Throughput:
  - With sto_tready held high, no bubbles between samples: the last repetition and the next input accept occur in the same cycle.
  - divider=0 gives 1 output per input at 1 sample/clk (pass-through with one register stage).
- Back-pressure:
  - While sto_tready=0, sto_tvalid/sto_tdata/sto_tlast stay stable and cnt holds.
  - A held sample is never dropped, duplicated beyond d+1, or overwritten before its last out_xfer.
- Width: cnt decrements only when nonzero, so there is no wrap. Max divider 2^CW-1 gives 2^CW repetitions.
- Simultaneous events:
  - wrDivider with in_xfer: the accepted sample uses the old divider.
  - Last out_xfer with in_xfer: the new sample loads and full stays 1.
- Reset mid-operation: the held sample is discarded immediately (asynchronously), sto_tvalid drops to 0 without waiting for a clock, and the divider returns to 0.

Test Plan:
1. Reset/idle: assert rst_n=0 mid-stream holding a sample with cnt=5 -> sto_tvalid=0, sto_tlast=0, sti_tready=1 immediately; after release, divider=0 (next sample emitted once).
2. Pass-through: divider=0, sto_tready=1, 8 back-to-back inputs 0x00..0x07 -> outputs 0x00..0x07 one per clk, each with sto_tlast=1, sti_tready constantly 1, first output one cycle after first accept.
3. Stretch: write cmd_data=0x00000003, send 0xA5A5A5A5 then 0x5A5A5A5A with sto_tready=1 -> 4 cycles of 0xA5A5A5A5 (tlast on 4th), then 4 of 0x5A5A5A5A, no gap; sti_tready high only on the 4th cycle of each.
4. Back-pressure: divider=2, random sto_tready (≈50%) and sti_tvalid over 200 samples -> scoreboard sees each sample exactly 3 times in order, with tlast on every 3rd, and data stable whenever valid & ~ready.
5. Divider change mid-sample: divider=4, accept sample S1, after 2 outputs write divider=1 -> S1 still emitted 5 times total; next sample S2 emitted 2 times. wrDivider in the same cycle as S2 accept -> S2 uses the previous value.
6. Upper bits/max: write cmd_data=0xFF000002 -> 3 repetitions (bits 31:24 ignored). Write 0x00FFFFFF with CW reduced to 4 via parameter -> 16 repetitions, cnt never wraps below 0.

Source files
------------

// File: rtl/sample_stretcher_if.sv
// ---------------------------------------------------------------------------
// sample_stretcher_if
// Stream bundle for the sample stretcher. It carries an input sample stream
// (sti_*) and an output replay stream (sto_*).
//   sti_tvalid / sti_tdata / sti_tready : decimated samples into the stretcher
//   sto_tvalid / sto_tdata / sto_tlast / sto_tready : full-rate replayed stream
// The slave modport is the stretcher. The master modport is the source and
// sink around it, such as the pattern generator and the replay consumer.
// ---------------------------------------------------------------------------
interface sample_stretcher_if #(
    parameter int DW = 32
);
    logic          sti_tready;
    logic          sti_tvalid;
    logic [DW-1:0] sti_tdata;
    logic          sto_tready;
    logic          sto_tvalid;
    logic [DW-1:0] sto_tdata;
    logic          sto_tlast;

    modport master (
        input  sti_tready,
        output sti_tvalid,
        output sti_tdata,
        output sto_tready,
        input  sto_tvalid,
        input  sto_tdata,
        input  sto_tlast
    );

    modport slave (
        output sti_tready,
        input  sti_tvalid,
        input  sti_tdata,
        input  sto_tready,
        output sto_tvalid,
        output sto_tdata,
        output sto_tlast
    );
endinterface

// File: rtl/sample_stretcher.sv
// ---------------------------------------------------------------------------
// sample_stretcher
// Replays each input sample (divider+1) times on the output stream. This
// turns decimated sample memory back into a full-rate stream.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   wrDivider  one-cycle strobe: divider <= cmd_data[CW-1:0]
//   cmd_data   configuration data (bits above CW-1 are ignored)
//   st         stream bundle (slave side): sti_* in, sto_* out
//   busy       holding register occupied (same as sto_tvalid)
// A single holding register (data_q/full_q) feeds the output. cnt_q counts
// the extra repetitions still owed. The last repetition can hand over to the
// next input sample in the same cycle, so a ready sink sees no bubbles.
// ---------------------------------------------------------------------------
module sample_stretcher #(
    parameter int DW = 32,
    parameter int CW = 24
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wrDivider,
    input  logic [31:0]         cmd_data,
    sample_stretcher_if.slave   st,
    output logic                busy
);

    logic [CW-1:0] divider_q, divider_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [DW-1:0] data_q,    data_d;
    logic          full_q,    full_d;

    logic last;
    logic sti_ready;
    logic in_xfer;
    logic out_xfer;

    // The divider field only occupies the low CW bits of the command word.
    if (CW < 32) begin : g_cmd_hi
        logic unused_cmd_hi;
        assign unused_cmd_hi = ^cmd_data[31:CW];
    end

    assign last      = (cnt_q == '0);
    // Input may enter when empty, or when the held sample leaves this cycle.
    // This path depends on sto_tready only, never on sti_tvalid.
    assign sti_ready = ~full_q | (st.sto_tready & last);
    assign in_xfer   = st.sti_tvalid & sti_ready;
    assign out_xfer  = full_q & st.sto_tready;

    assign st.sti_tready = sti_ready;
    assign st.sto_tvalid = full_q;
    assign st.sto_tdata  = data_q;
    assign st.sto_tlast  = full_q & last;
    assign busy          = full_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        divider_d = divider_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        full_d    = full_q;

        if (wrDivider) begin
            divider_d = cmd_data[CW-1:0];
        end

        // The accepted sample latches divider_q, which is the value before
        // any write on the same edge. A held count is never reloaded from a
        // new divider.
        if (in_xfer) begin
            data_d = st.sti_tdata;
            cnt_d  = divider_q;
            full_d = 1'b1;
        end else if (out_xfer && last) begin
            full_d = 1'b0;
        end else if (out_xfer) begin
            // cnt_q is non-zero here, so the counter cannot wrap.
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divider_q <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            full_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            divider_q <= divider_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            full_q    <= full_d;
        end
    end

endmodule

// File: tb/tb_sample_stretcher.sv
// ---------------------------------------------------------------------------
// tb_sample_stretcher
// Scoreboard bench for sample_stretcher. An input monitor pushes the
// hand-computed repetition list for each accepted sample (count set by the
// stimulus in cur_reps). An output monitor pops one entry per output
// transfer and compares the data and the last flag. A second instance with
// CW=4 covers the maximum-divider case.
// ---------------------------------------------------------------------------
module tb_sample_stretcher;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_divider = 1'b0;
    logic [31:0] cmd_data = '0;
    logic        busy;
    logic        wr_divider2 = 1'b0;
    logic [31:0] cmd_data2 = '0;
    logic        busy2;

    int checks = 0;
    int errors = 0;
    int cur_reps = 1;
    bit rand_ready = 1'b0;

    exp_t exp_q[$];

    sample_stretcher_if #(.DW(32)) bus ();
    sample_stretcher_if #(.DW(32)) bus2 ();

    sample_stretcher #(.DW(32), .CW(24)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrDivider (wr_divider),
        .cmd_data  (cmd_data),
        .st        (bus),
        .busy      (busy)
    );

    sample_stretcher #(.DW(32), .CW(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrDivider (wr_divider2),
        .cmd_data  (cmd_data2),
        .st        (bus2),
        .busy      (busy2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Input monitor: record the expected repetitions of every accepted sample.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.sti_tvalid && bus.sti_tready) begin
                for (int r = 0; r < cur_reps; r++) begin
                    exp_q.push_back('{data: bus.sti_tdata, last: (r == cur_reps - 1)});
                end
            end
        end
    end

    // Output monitor: pop and compare on each output transfer, and check
    // that the output stays stable while it is stalled.
    initial begin
        exp_t        e;
        bit          hold_pend = 1'b0;
        logic [31:0] hold_data = '0;
        logic        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.sto_tvalid) begin
                if (hold_pend) begin
                    check("stall_data_stable", bus.sto_tdata, hold_data);
                    check("stall_last_stable", bus.sto_tlast, hold_last);
                end
                if (bus.sto_tready) begin
                    hold_pend = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_output: got data 0x%0h with nothing expected at %0t",
                                 bus.sto_tdata, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", bus.sto_tdata, e.data);
                        check("out_last", bus.sto_tlast, e.last);
                        check("busy_eq_valid", busy, 1'b1);
                    end
                end else begin
                    hold_pend = 1'b1;
                    hold_data = bus.sto_tdata;
                    hold_last = bus.sto_tlast;
                end
            end else begin
                hold_pend = 1'b0;
            end
        end
    end

    // Random sink back-pressure, enabled only during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.sto_tready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d expected outputs pending", exp_q.size());
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog expired");
    end

    task automatic write_div(input logic [31:0] v);
        @(posedge clk);
        #1;
        cmd_data   = v;
        wr_divider = 1'b1;
        @(posedge clk);
        #1;
        wr_divider = 1'b0;
    endtask

    // Present one sample and hold it until it is accepted (bounded).
    task automatic send(input logic [31:0] d, input int reps);
        cur_reps      = reps;
        bus.sti_tdata  = d;
        bus.sti_tvalid = 1'b1;
        for (int w = 0; w < 500; w++) begin
            @(negedge clk);
            if (bus.sti_tready) begin
                @(posedge clk);
                #1;
                bus.sti_tvalid = 1'b0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: sample 0x%0h not accepted within 500 cycles", d);
        bus.sti_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int w = 0; w < 3000 && exp_q.size() != 0; w++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected outputs still pending, required 0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_out;
        int n_last;
        int last_at;

        bus.sti_tvalid  = 1'b0;
        bus.sti_tdata   = '0;
        bus.sto_tready  = 1'b1;
        bus2.sti_tvalid = 1'b0;
        bus2.sti_tdata  = '0;
        bus2.sto_tready = 1'b1;

        // Reset state.
        #1;
        check("rst_sto_tvalid", bus.sto_tvalid, 1'b0);
        check("rst_sto_tlast",  bus.sto_tlast,  1'b0);
        check("rst_sti_tready", bus.sti_tready, 1'b1);
        check("rst_busy",       busy,           1'b0);
        check("rst_sto_tdata",  bus.sto_tdata,  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Pass-through with divider=0: one output per clock, each tlast.
        cur_reps = 1;
        for (int i = 0; i < 8; i++) begin
            bus.sti_tdata  = 32'(i);
            bus.sti_tvalid = 1'b1;
            @(negedge clk);
            check("pt_sti_tready", bus.sti_tready, 1'b1);
            if (i > 0) begin
                check("pt_valid", bus.sto_tvalid, 1'b1);
                check("pt_data",  bus.sto_tdata,  32'(i - 1));
                check("pt_last",  bus.sto_tlast,  1'b1);
            end
            @(posedge clk);
            #1;
        end
        bus.sti_tvalid = 1'b0;
        @(negedge clk);
        check("pt_final_data", bus.sto_tdata, 32'h7);
        drain("pt_drain");

        // Stretch by 4 with no gap between samples.
        write_div(32'h0000_0003);
        cur_reps       = 4;
        bus.sti_tdata  = 32'hA5A5_A5A5;
        bus.sti_tvalid = 1'b1;
        @(negedge clk);
        check("st_rdy_empty", bus.sti_tready, 1'b1);
        @(posedge clk);
        #1;
        bus.sti_tdata = 32'h5A5A_5A5A;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("st_a_valid", bus.sto_tvalid, 1'b1);
            check("st_a_data",  bus.sto_tdata,  32'hA5A5_A5A5);
            check("st_a_rdy",   bus.sti_tready, (k == 3));
            check("st_a_last",  bus.sto_tlast,  (k == 3));
            @(posedge clk);
            #1;
            if (k == 3) bus.sti_tvalid = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("st_b_valid", bus.sto_tvalid, 1'b1);
            check("st_b_data",  bus.sto_tdata,  32'h5A5A_5A5A);
            check("st_b_rdy",   bus.sti_tready, (k == 3));
            check("st_b_last",  bus.sto_tlast,  (k == 3));
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("st_idle_valid", bus.sto_tvalid, 1'b0);
        drain("st_drain");

        // Divider change while a sample is held, then a write on the accept edge.
        write_div(32'h0000_0004);
        send(32'h1111_0001, 5);
        write_div(32'h0000_0001);
        send(32'h2222_0002, 2);
        drain("dc_drain1");
        cmd_data       = 32'h0000_0006;
        wr_divider     = 1'b1;
        cur_reps       = 2;
        bus.sti_tdata  = 32'h3333_0003;
        bus.sti_tvalid = 1'b1;
        @(negedge clk);
        check("dc_same_edge_rdy", bus.sti_tready, 1'b1);
        @(posedge clk);
        #1;
        wr_divider     = 1'b0;
        bus.sti_tvalid = 1'b0;
        send(32'h4444_0004, 7);
        drain("dc_drain2");

        // Upper command bits are ignored.
        write_div(32'hFF00_0002);
        send(32'hCAFE_0001, 3);
        send(32'hCAFE_0002, 3);
        drain("ub_drain");

        // Random source gaps and sink back-pressure, divider=2.
        write_div(32'h0000_0002);
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send($urandom, 3);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        bus.sto_tready = 1'b1;
        drain("bp_drain");

        // CW=4 instance: 0x00FFFFFF truncates to 15, giving 16 repetitions.
        @(posedge clk);
        #1;
        cmd_data2   = 32'h00FF_FFFF;
        wr_divider2 = 1'b1;
        @(posedge clk);
        #1;
        wr_divider2     = 1'b0;
        bus2.sti_tdata  = 32'h00C0_FFEE;
        bus2.sti_tvalid = 1'b1;
        @(negedge clk);
        check("max_rdy", bus2.sti_tready, 1'b1);
        @(posedge clk);
        #1;
        bus2.sti_tvalid = 1'b0;
        n_out   = 0;
        n_last  = 0;
        last_at = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (bus2.sto_tvalid) begin
                n_out++;
                check("max_data", bus2.sto_tdata, 32'h00C0_FFEE);
                if (bus2.sto_tlast) begin
                    n_last++;
                    last_at = n_out;
                end
            end
        end
        check("max_reps",    32'(n_out),   32'd16);
        check("max_n_last",  32'(n_last),  32'd1);
        check("max_last_at", 32'(last_at), 32'd16);
        check("max_idle",    busy2,        1'b0);

        // Asynchronous reset while holding a sample with cnt=5.
        write_div(32'h0000_0005);
        bus.sto_tready = 1'b0;
        send(32'hDEAD_BEEF, 6);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ar_pre_valid", bus.sto_tvalid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", bus.sto_tvalid, 1'b0);
        check("ar_last",  bus.sto_tlast,  1'b0);
        check("ar_rdy",   bus.sti_tready, 1'b1);
        check("ar_busy",  busy,           1'b0);
        check("ar_data",  bus.sto_tdata,  32'h0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.sto_tready = 1'b1;
        send(32'h1234_5678, 1);
        drain("ar_drain");
        @(negedge clk);
        check("ar_end_idle", bus.sto_tvalid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
